// File: rtl/eth_pcs_pkg.sv
// Shared definitions for the 10G/25G PCS receive path.
//   SYNC_DATA / SYNC_CTRL : the two legal 64b/66b sync headers
//   lock_state_e          : block-lock state machine encoding
//   offset_width()        : width of a bit offset into a DATA_WIDTH+2 block
package eth_pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  typedef enum logic [1:0] {
    StLockInit = 2'd0,
    StTest     = 2'd1,
    StSlipWait = 2'd2
  } lock_state_e;

  function automatic int unsigned offset_width(input int unsigned data_width);
    return $clog2(data_width + 2);
  endfunction

endpackage

// File: rtl/eth_rx_barrel_shift.sv
// 2W-to-W alignment window for internal bit slipping.
//   clk, rst_n : clock, asynchronous active-low reset
//   blk_i      : current raw block {data, hdr}
//   valid_i    : blk_i qualifier; the previous block register only moves on valid
//   offset_i   : bit offset into the {blk, prev_blk} window
//   aligned_o  : combinational aligned block
module eth_rx_barrel_shift #(
  parameter int unsigned Width = 66,
  parameter int unsigned OffW  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] blk_i,
  input  logic             valid_i,
  input  logic [OffW-1:0]  offset_i,
  output logic [Width-1:0] aligned_o
);

  logic [Width-1:0]   prev_q;
  logic [2*Width-1:0] win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (valid_i) begin
      prev_q <= blk_i;
    end
  end

  // Older bits sit in the low half, so a larger offset selects later-received bits.
  assign win       = {blk_i, prev_q};
  assign aligned_o = win[offset_i +: Width];

endmodule

// File: rtl/eth_phy_rx_block_sync.sv
// 64b/66b block-lock engine between the SERDES/gearbox and the descrambler.
//   clk, rst_n               : clock, asynchronous active-low reset
//   i_serdes_rx_hdr/data     : raw header and payload slots (hdr bit 0 received first)
//   i_serdes_rx_valid        : input word qualifier
//   o_serdes_rx_*_align      : aligned block, one cycle after the input
//   o_rx_block_lock          : block lock status
//   o_serdes_rx_bitslip      : one-cycle slip request (external slip mode only)
//   o_bit_offset             : current internal shift (0 in external slip mode)
//   o_slip_count             : saturating number of slips since reset
module eth_phy_rx_block_sync
  import eth_pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned SLIP_MODE      = 0,
  parameter int unsigned SH_CNT_LOCK    = 64,
  parameter int unsigned SH_INVALID_MAX = 16,
  parameter int unsigned SLIP_HOLDOFF   = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            i_serdes_rx_hdr,
  input  logic [DATA_WIDTH-1:0]                 i_serdes_rx_data,
  input  logic                                  i_serdes_rx_valid,
  output logic [1:0]                            o_serdes_rx_hdr_align,
  output logic [DATA_WIDTH-1:0]                 o_serdes_rx_data_align,
  output logic                                  o_serdes_rx_valid_align,
  output logic                                  o_rx_block_lock,
  output logic                                  o_serdes_rx_bitslip,
  output logic [offset_width(DATA_WIDTH)-1:0]   o_bit_offset,
  output logic [CNT_WIDTH-1:0]                  o_slip_count
);

  localparam int unsigned W    = DATA_WIDTH + 2;
  localparam int unsigned OffW = offset_width(DATA_WIDTH);
  localparam int unsigned CntW = $clog2(SH_CNT_LOCK + 1);

  logic [W-1:0] blk;
  logic [W-1:0] aligned;

  lock_state_e          state_q;
  logic [CntW-1:0]      sh_cnt_q;
  logic [CntW-1:0]      inv_cnt_q;
  logic [3:0]           hold_q;
  logic                 lock_q;
  logic                 bitslip_q;
  logic [OffW-1:0]      offset_q;
  logic [CNT_WIDTH-1:0] slip_cnt_q;

  logic [1:0]            hdr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  logic            sh_valid;
  logic [CntW-1:0] sh_cnt_next;
  logic [CntW-1:0] inv_next;
  logic            do_slip;

  assign blk = {i_serdes_rx_data, i_serdes_rx_hdr};

  if (SLIP_MODE == 0) begin : g_int_slip
    eth_rx_barrel_shift #(
      .Width (W),
      .OffW  (OffW)
    ) u_barrel_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_i     (blk),
      .valid_i   (i_serdes_rx_valid),
      .offset_i  (offset_q),
      .aligned_o (aligned)
    );
  end else begin : g_ext_slip
    // The SERDES moves the word boundary itself, so the block is already in place.
    assign aligned = blk;
  end

  always_comb begin
    sh_valid    = (aligned[1:0] == SYNC_DATA) || (aligned[1:0] == SYNC_CTRL);
    sh_cnt_next = sh_cnt_q + 1'b1;
    inv_next    = inv_cnt_q + {{(CntW-1){1'b0}}, ~sh_valid};
    do_slip     = ~sh_valid && (~lock_q || (inv_next == CntW'(SH_INVALID_MAX)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLockInit;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      hold_q     <= '0;
      lock_q     <= 1'b0;
      bitslip_q  <= 1'b0;
      offset_q   <= '0;
      slip_cnt_q <= '0;
    end else begin
      bitslip_q <= 1'b0;
      unique case (state_q)
        StLockInit: state_q <= StTest;
        StTest, StSlipWait: begin
          if (i_serdes_rx_valid) begin
            if (hold_q != 4'd0) begin
              // Blocks right after a slip straddle the old boundary; skip them.
              hold_q <= hold_q - 4'd1;
              if (hold_q == 4'd1) state_q <= StTest;
            end else if (do_slip) begin
              lock_q    <= 1'b0;
              sh_cnt_q  <= '0;
              inv_cnt_q <= '0;
              hold_q    <= 4'(SLIP_HOLDOFF);
              state_q   <= (SLIP_HOLDOFF == 0) ? StTest : StSlipWait;
              if (~&slip_cnt_q) slip_cnt_q <= slip_cnt_q + 1'b1;
              if (SLIP_MODE == 0) begin
                offset_q <= (offset_q == OffW'(W - 1)) ? '0 : offset_q + 1'b1;
              end else begin
                bitslip_q <= 1'b1;
              end
            end else if (sh_cnt_next == CntW'(SH_CNT_LOCK)) begin
              if (inv_next == '0) lock_q <= 1'b1;
              sh_cnt_q  <= '0;
              inv_cnt_q <= '0;
            end else begin
              sh_cnt_q  <= sh_cnt_next;
              inv_cnt_q <= inv_next;
            end
          end
        end
        default: state_q <= StLockInit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= i_serdes_rx_valid;
      if (i_serdes_rx_valid) begin
        hdr_q  <= aligned[1:0];
        data_q <= aligned[W-1:2];
      end
    end
  end

  assign o_serdes_rx_hdr_align   = hdr_q;
  assign o_serdes_rx_data_align  = data_q;
  assign o_serdes_rx_valid_align = valid_q;
  assign o_rx_block_lock         = lock_q;
  assign o_serdes_rx_bitslip     = (SLIP_MODE == 1) ? bitslip_q : 1'b0;
  assign o_bit_offset            = offset_q;
  assign o_slip_count            = slip_cnt_q;

endmodule

// File: tb/tb_eth_phy_rx_block_sync.sv
// Bench for eth_phy_rx_block_sync: one internal-slip and one external-slip instance,
// a reference model feeding an expectation queue, and a table of stimulus phases.
module tb_eth_phy_rx_block_sync;

  localparam int W = 66;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  a_hdr, a_hdr_o, b_hdr, b_hdr_o;
  logic [63:0] a_data, a_data_o, b_data, b_data_o;
  logic        a_valid, a_valid_o, a_lock, a_bitslip;
  logic        b_valid, b_valid_o, b_lock, b_bitslip;
  logic [6:0]  a_off, b_off;
  logic [15:0] a_slips, b_slips;

  eth_phy_rx_block_sync #(.SLIP_MODE(0)) u_int (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_serdes_rx_hdr         (a_hdr),
    .i_serdes_rx_data        (a_data),
    .i_serdes_rx_valid       (a_valid),
    .o_serdes_rx_hdr_align   (a_hdr_o),
    .o_serdes_rx_data_align  (a_data_o),
    .o_serdes_rx_valid_align (a_valid_o),
    .o_rx_block_lock         (a_lock),
    .o_serdes_rx_bitslip     (a_bitslip),
    .o_bit_offset            (a_off),
    .o_slip_count            (a_slips)
  );

  eth_phy_rx_block_sync #(.SLIP_MODE(1)) u_ext (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_serdes_rx_hdr         (b_hdr),
    .i_serdes_rx_data        (b_data),
    .i_serdes_rx_valid       (b_valid),
    .o_serdes_rx_hdr_align   (b_hdr_o),
    .o_serdes_rx_data_align  (b_data_o),
    .o_serdes_rx_valid_align (b_valid_o),
    .o_rx_block_lock         (b_lock),
    .o_serdes_rx_bitslip     (b_bitslip),
    .o_bit_offset            (b_off),
    .o_slip_count            (b_slips)
  );

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        valid;
    logic        lock;
    logic        bitslip;
    logic [6:0]  off;
    logic [15:0] slips;
  } obs_t;

  typedef struct {
    string name;
    bit    rst;
    int    shift;
    int    nblk;
    int    nbad;
    bit    toggle;
    bit    until_lock;
    int    budget;
    bit    exp_lock;
    int    exp_slips;
    int    exp_off;
  } phase_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit             m_ext;
  bit             m_init;
  logic [W-1:0]   m_prev;
  int             m_off, m_sh, m_inv, m_hold, m_slips;
  bit             m_lock;
  obs_t           m_out;
  obs_t           exp_q[$];
  obs_t           last_obs;
  logic [2*W-1:0] src_pair;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic obs_t observe();
    obs_t o;
    if (m_ext) o = '{b_hdr_o, b_data_o, b_valid_o, b_lock, b_bitslip, b_off, b_slips};
    else       o = '{a_hdr_o, a_data_o, a_valid_o, a_lock, a_bitslip, a_off, a_slips};
    return o;
  endfunction

  task automatic model_reset();
    m_init = 1'b1; m_prev = '0; m_off = 0; m_sh = 0; m_inv = 0; m_hold = 0;
    m_slips = 0; m_lock = 1'b0; m_out = '0; exp_q.delete();
  endtask

  // Expected registered outputs after the coming clock edge.
  task automatic model_step(input logic [1:0] hdr, input logic [63:0] data, input logic valid);
    logic [W-1:0]   blk, al;
    logic [2*W-1:0] win;
    bit             good;
    m_out.bitslip = 1'b0;
    m_out.valid   = valid;
    if (valid) begin
      blk = {data, hdr};
      if (m_ext) begin
        al = blk;
      end else begin
        win    = {blk, m_prev} >> m_off;
        al     = win[W-1:0];
        m_prev = blk;
      end
      m_out.hdr  = al[1:0];
      m_out.data = al[W-1:2];
      if (!m_init) begin
        if (m_hold > 0) begin
          m_hold--;
        end else begin
          good = (al[1:0] == 2'b01) || (al[1:0] == 2'b10);
          if (!good && (!m_lock || (m_inv + 1 == 16))) begin
            m_lock = 1'b0; m_sh = 0; m_inv = 0; m_hold = 2;
            if (m_slips < 65535) m_slips++;
            if (m_ext) m_out.bitslip = 1'b1;
            else m_off = (m_off == W - 1) ? 0 : m_off + 1;
          end else begin
            m_sh++;
            if (!good) m_inv++;
            if (m_sh == 64) begin
              if (m_inv == 0) m_lock = 1'b1;
              m_sh = 0; m_inv = 0;
            end
          end
        end
      end
    end
    m_init      = 1'b0;
    m_out.lock  = m_lock;
    m_out.off   = 7'(m_off);
    m_out.slips = 16'(m_slips);
    exp_q.push_back(m_out);
  endtask

  // Next raw slot of a block stream whose true boundary sits at bit `shift` of each slot.
  task automatic gen_slot(input int shift, input bit bad, output logic [1:0] hdr,
                          output logic [63:0] data);
    logic [W-1:0] b, slot;
    if (bad) b[1:0] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    else     b[1:0] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    b[W-1:2] = {$urandom, $urandom};
    src_pair = {b, src_pair[2*W-1:W]};
    slot     = src_pair[(W - shift) +: W];
    hdr      = slot[1:0];
    data     = slot[W-1:2];
  endtask

  task automatic cycle(input logic [1:0] hdr, input logic [63:0] data, input logic valid);
    obs_t exp;
    if (m_ext) begin b_hdr = hdr; b_data = data; b_valid = valid; end
    else       begin a_hdr = hdr; a_data = data; a_valid = valid; end
    model_step(hdr, data, valid);
    @(posedge clk);
    @(negedge clk);
    last_obs = observe();
    exp = exp_q.pop_front();
    check("ctl", 128'({last_obs.valid, last_obs.lock, last_obs.bitslip, last_obs.off,
                       last_obs.slips}),
          128'({exp.valid, exp.lock, exp.bitslip, exp.off, exp.slips}));
    check("data", 128'({last_obs.hdr, last_obs.data}), 128'({exp.hdr, exp.data}));
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    a_valid = 1'b0; a_hdr = '0; a_data = '0;
    b_valid = 1'b0; b_hdr = '0; b_data = '0;
    #1;
    check("reset_int", 128'({a_hdr_o, a_data_o, a_valid_o, a_lock, a_bitslip, a_off, a_slips}),
          128'(0));
    check("reset_ext", 128'({b_hdr_o, b_data_o, b_valid_o, b_lock, b_bitslip, b_off, b_slips}),
          128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    phase_t      phases[6];
    logic [1:0]  h;
    logic [63:0] d;
    int          vcount, cyc, first_lock, s, pulses;
    bit          v, was_high;

    phases[0] = '{"aligned", 1, 0, 193, 0, 0, 0, 400, 1, 0, 0};
    phases[1] = '{"bad15", 0, 0, 64, 15, 0, 0, 200, 1, 0, 0};
    phases[2] = '{"bad16", 0, 0, 17, 16, 0, 0, 100, 0, 1, 1};
    phases[3] = '{"wrap", 0, 0, 0, 0, 1, 1, 8000, 1, 66, 0};
    phases[4] = '{"midwin", 0, 0, 30, 0, 0, 0, 100, 1, 66, 0};
    phases[5] = '{"shift17", 1, 17, 0, 0, 0, 1, 8000, 1, 17, 17};

    a_valid = 1'b0; a_hdr = '0; a_data = '0;
    b_valid = 1'b0; b_hdr = '0; b_data = '0;
    src_pair = '0;
    m_ext = 1'b0;
    model_reset();
    last_obs = '0;

    for (int p = 0; p < 6; p++) begin
      if (phases[p].rst) do_reset();
      vcount = 0; cyc = 0; first_lock = -1;
      while (phases[p].until_lock ? !m_lock : (vcount < phases[p].nblk)) begin
        if (cyc >= phases[p].budget) break;
        v = phases[p].toggle ? (cyc % 2 == 0) : 1'b1;
        if (v) gen_slot(phases[p].shift, vcount < phases[p].nbad, h, d);
        else begin h = 2'($urandom); d = {$urandom, $urandom}; end
        cycle(h, d, v);
        if (v) vcount++;
        if (last_obs.lock && first_lock < 0) first_lock = vcount - 1;
        cyc++;
      end
      if (phases[p].until_lock) begin
        n_checks++;
        if (m_lock) n_pass++;
        else $display("FAIL %s_timeout: no lock after %0d cycles, required lock", phases[p].name,
                      cyc);
      end
      check({phases[p].name, "_lock"}, 128'(a_lock), 128'(phases[p].exp_lock));
      check({phases[p].name, "_slips"}, 128'(a_slips), 128'(phases[p].exp_slips));
      check({phases[p].name, "_offset"}, 128'(a_off), 128'(phases[p].exp_off));
      // Priming block goes in during the init cycle, so evaluated block 64 is input 64.
      if (p == 0) check("lock_at_block_64", 128'(first_lock), 128'(64));
    end

    // External slip: the source drops one bit per bitslip pulse, starting 5 bits late.
    do_reset();
    m_ext = 1'b1;
    s = 5; pulses = 0; cyc = 0; was_high = 1'b0; last_obs = '0;
    while (!m_lock && cyc < 4000) begin
      if (last_obs.bitslip) s = (s == 0) ? W - 1 : s - 1;
      gen_slot(s, 1'b0, h, d);
      cycle(h, d, 1'b1);
      if (last_obs.bitslip) begin
        check("pulse_width", 128'(was_high), 128'(0));
        pulses++;
      end
      was_high = last_obs.bitslip;
      cyc++;
    end
    n_checks++;
    if (m_lock) n_pass++;
    else $display("FAIL ext_timeout: no lock after %0d cycles, required lock", cyc);
    check("ext_lock", 128'(b_lock), 128'(1));
    check("ext_slips", 128'(b_slips), 128'(5));
    check("ext_pulses", 128'(pulses), 128'(5));
    check("ext_offset", 128'(b_off), 128'(0));
    check("int_bitslip_tied", 128'(a_bitslip), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_phy_rx_block_sync.md
# eth_phy_rx_block_sync

Parametrised 64b/66b block-lock engine for the 10G/25G PCS receive path, sitting between the SERDES (or gearbox) output and the descrambler. It runs the IEEE 802.3 Clause 49 lock state machine with configurable thresholds and supports two slip modes: an internal barrel shifter, or an external SERDES bitslip pulse. It also supports gapped input (valid qualifier), post-slip holdoff, and a saturating slip counter for link diagnostics.

## Interface
- `DATA_WIDTH`, 64: block payload width in bits. The sync header is fixed at 2 bits. Block width `W = DATA_WIDTH + 2`.
- `SLIP_MODE`, 0: selects how a slip is applied.
  - 0 = internal barrel shift.
  - 1 = external `o_serdes_rx_bitslip` pulse.
- `SH_CNT_LOCK`, 64: blocks per evaluation window (range 2..1024).
- `SH_INVALID_MAX`, 16: invalid headers per window that drop lock (range 1..`SH_CNT_LOCK`).
- `SLIP_HOLDOFF`, 2: valid blocks ignored after each slip (range 0..15).
- `CNT_WIDTH`, 16: width of the slip counter.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous assert, active-low reset.
- `i_serdes_rx_hdr`  in  2: raw header slot; bit 0 is received first.
- `i_serdes_rx_data`  in  `DATA_WIDTH`: raw payload slot.
- `i_serdes_rx_valid`  in  1: input word qualifier.
- `o_serdes_rx_hdr_align`  out  2: aligned sync header.
- `o_serdes_rx_data_align`  out  `DATA_WIDTH`: aligned payload.
- `o_serdes_rx_valid_align`  out  1: output qualifier.
- `o_rx_block_lock`  out  1: block lock status.
- `o_serdes_rx_bitslip`  out  1: one-cycle slip request (`SLIP_MODE=1` only; otherwise tied to 0).
- `o_bit_offset`  out  `$clog2(W)`: current internal shift (0 when `SLIP_MODE=1`).
- `o_slip_count`  out  `CNT_WIDTH`: saturating count of slips since reset.

## Operation
- **Block packing:** `blk = {data, hdr}`, so the header occupies `blk[1:0]`.
- **Internal mode:**
  - `prev_blk` is updated to the current `blk` on every valid input.
  - Alignment window: `win = {blk, prev_blk}` (2W bits).
  - `aligned = win[offset +: W]`.
- **External mode:** `aligned = blk`.
- **Header validity:** `sh_valid = aligned[0] ^ aligned[1]`, i.e. header `01` or `10`.
- **Evaluation:** happens once per valid input, unless `holdoff_cnt != 0`. Skipped blocks decrement `holdoff_cnt` and still pass to the output.
- **States:** `LOCK_INIT`, `TEST`, `SLIP_WAIT`.
  - `LOCK_INIT` occupies exactly one cycle after reset release, then moves to `TEST`.
  - `SLIP_WAIT` is active while `holdoff_cnt > 0`, then returns to `TEST`.
- **Counter update on each evaluated block:**
  - `sh_cnt_next = sh_cnt + 1`.
  - `inv_next = inv_cnt + !sh_valid`.
- **Slip priority:** slip if `!sh_valid && (!lock || inv_next == SH_INVALID_MAX)`. A slip:
  - clears lock, `sh_cnt` and `inv_cnt`;
  - sets `holdoff_cnt = SLIP_HOLDOFF`;
  - increments `o_slip_count` (saturates at all-ones, never wraps);
  - in internal mode, increments `offset`, wrapping `W-1 -> 0`;
  - in external mode, pulses `o_serdes_rx_bitslip` for exactly one cycle.
- **Window end:** otherwise, if `sh_cnt_next == SH_CNT_LOCK`:
  - set lock if `inv_next == 0`; otherwise lock is unchanged;
  - clear both counters.
- **Otherwise:** store `sh_cnt_next` and `inv_next`.
- **Locked-state tolerance:** while locked, fewer than `SH_INVALID_MAX` bad headers in a window keep lock.
- **Offset persistence:** `offset` persists through lock loss and is never reset except by `rst_n`.
- **Unqualified inputs:** no state, counter or pipeline change when `i_serdes_rx_valid = 0`.

## Timing
- **Reset values:** all outputs are 0. `offset`, counters, holdoff and `prev_blk` are cleared. State is `LOCK_INIT`.
- **Datapath latency:** exactly 1 cycle. Aligned outputs and `o_serdes_rx_valid_align` are registered from the same-cycle input.
- **Control outputs:** `o_rx_block_lock`, `o_bit_offset` and `o_slip_count` change on the clock edge that evaluates the deciding block.
- **Slip effect:** the new offset applies to the next valid input.
- **Bitslip pulse:** `o_serdes_rx_bitslip` is high on the cycle after the deciding edge. A back-to-back slip is impossible unless `SLIP_HOLDOFF = 0` and valid is asserted on consecutive cycles; in that case pulses may be adjacent.
- **Mid-operation reset:** `rst_n` low mid-operation clears everything asynchronously. Removal should be synchronised externally.

## Structure
- Shared package `eth_pcs_pkg` holds:
  - `SYNC_DATA = 2'b10`, `SYNC_CTRL = 2'b01`;
  - the state enum encoding;
  - a helper for the offset width, `$clog2(W)`.
- Natural sub-module: `eth_rx_barrel_shift`, a 2W-to-W window select (combinational plus `prev_blk` register). It is instantiated only when `SLIP_MODE = 0`.

## Test plan
- **Aligned `01`/`10` stream, valid every cycle, offset 0:** lock asserts on the edge evaluating block 64 (`SH_CNT_LOCK`). No slips; `o_slip_count = 0`.
- **Stream pre-shifted by 17 bits, internal mode:**
  - expect 17 slips and `o_bit_offset = 17`;
  - expect lock 64 evaluated blocks after the last slip, with each slip followed by 2 skipped blocks;
  - output headers valid after lock.
- **Locked, then inject 15 bad headers in one window:** lock is held. **Inject 16 bad headers:** lock drops on the 16th, `o_slip_count` increments by 1, and offset advances.
- **`SLIP_MODE = 1`, misaligned source model that reacts to bitslip:** exactly one 1-cycle pulse per slip, `o_bit_offset` stays 0, and lock is eventually reached.
- **Valid toggling 1,0,1,0 with offset wrap from `W-1 = 65` to 0:** counters advance only on valid cycles and offset wraps to 0. Then assert `rst_n = 0` mid-window: all outputs are 0 immediately, and relock restarts from `LOCK_INIT`.
